hw_fw_timer: RTL and testbench

//   Interval timer for the highway/farm-road controller. Divides clk into

---
 rtl/hw_fw_timer.sv | 133 +++++++++++++
 tb/tb_hw_fw_timer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_fw_timer.sv
// Interval timer: prescaled tick counter with level short/long timeouts for the highway FSM.
// Optional macro TMR_RUNTIME_CFG_EN adds runtime-loadable limits applied at the next restart.
module hw_fw_timer #(
    parameter int PRESCALE    = 1000,
    parameter int SHORT_TICKS = 5,
    parameter int LONG_TICKS  = 30,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_hw_reset,
`ifdef TMR_RUNTIME_CFG_EN
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_short,
    input  logic [CNT_W-1:0] cfg_long,
    output logic             cfg_err,
`endif
    output logic             tick,
    output logic             short_timeout,
    output logic             long_timeout,
    output logic [CNT_W-1:0] elapsed
);

    localparam int               PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] SHORT_INIT = CNT_W'(SHORT_TICKS);
    localparam logic [CNT_W-1:0] LONG_INIT  = CNT_W'(LONG_TICKS);

    generate
        if (PRESCALE < 1 || SHORT_TICKS < 1 || LONG_TICKS <= SHORT_TICKS ||
            LONG_TICKS > ((1 << CNT_W) - 1)) begin : g_param_check
            $error("hw_fw_timer: illegal PRESCALE/SHORT_TICKS/LONG_TICKS/CNT_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {S_SHORT, S_LONG, S_EXP} state_t;

    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] short_lim;
    logic [CNT_W-1:0] long_lim;
    logic             wrap;
    state_t           state;
    state_t           state_nxt;

    assign wrap = (pre_cnt == PRE_LAST);

`ifdef TMR_RUNTIME_CFG_EN
    logic [CNT_W-1:0] shadow_short;
    logic [CNT_W-1:0] shadow_long;
    logic             cfg_ok;

    assign cfg_ok = cfg_load && (cfg_short != '0) && (cfg_short < cfg_long);

    // A load coinciding with a restart takes effect immediately via the bypass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_short <= SHORT_INIT;
            shadow_long  <= LONG_INIT;
            short_lim    <= SHORT_INIT;
            long_lim     <= LONG_INIT;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_ok) begin
                shadow_short <= cfg_short;
                shadow_long  <= cfg_long;
            end
            if (timer_hw_reset) begin
                short_lim <= cfg_ok ? cfg_short : shadow_short;
                long_lim  <= cfg_ok ? cfg_long  : shadow_long;
            end
        end
    end
`else
    assign short_lim = SHORT_INIT;
    assign long_lim  = LONG_INIT;
`endif

    // Restart wins over a coincident prescaler wrap, so that tick is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            elapsed <= '0;
            tick    <= 1'b0;
        end else if (timer_hw_reset) begin
            pre_cnt <= '0;
            elapsed <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= wrap;
            pre_cnt <= wrap ? '0 : pre_cnt + 1'b1;
            if (wrap && (elapsed < long_lim)) begin
                elapsed <= elapsed + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_SHORT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (timer_hw_reset) begin
            state_nxt = S_SHORT;
        end else begin
            case (state)
                S_SHORT: if (elapsed >= short_lim) state_nxt = S_LONG;
                S_LONG:  if (elapsed >= long_lim)  state_nxt = S_EXP;
                S_EXP:   state_nxt = S_EXP;
                default: state_nxt = S_SHORT;
            endcase
        end
    end

    always_comb begin
        short_timeout = 1'b0;
        long_timeout  = 1'b0;
        case (state)
            S_LONG: short_timeout = 1'b1;
            S_EXP: begin
                short_timeout = 1'b1;
                long_timeout  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hw_fw_timer.sv
// Self-checking bench for hw_fw_timer: directed scenarios plus randomized restarts/resets
// checked against a cycles-since-restart reference model.
module tb_hw_fw_timer;

    localparam int P  = 4;
    localparam int S  = 2;
    localparam int L  = 5;
    localparam int P2 = 1;
    localparam int S2 = 1;
    localparam int L2 = 2;

    logic       clk;
    logic       reset;
    logic       timer_hw_reset;
    logic       tick, short_timeout, long_timeout;
    logic [7:0] elapsed;
    logic       restart2;
    logic       tick2, short2, long2;
    logic [7:0] elapsed2;
`ifdef TMR_RUNTIME_CFG_EN
    logic       cfg_load;
    logic [7:0] cfg_short, cfg_long;
    logic       cfg_err;
    logic       cfg_load2;
    logic [7:0] cfg_short2, cfg_long2;
    logic       cfg_err2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: edges since last restart/reset plus current limits.
    int k1, k2;
    int ls, ll, ss, sl;
    int err_exp;

    hw_fw_timer #(.PRESCALE(P), .SHORT_TICKS(S), .LONG_TICKS(L), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .timer_hw_reset(timer_hw_reset),
`ifdef TMR_RUNTIME_CFG_EN
        .cfg_load(cfg_load), .cfg_short(cfg_short), .cfg_long(cfg_long), .cfg_err(cfg_err),
`endif
        .tick(tick), .short_timeout(short_timeout), .long_timeout(long_timeout),
        .elapsed(elapsed)
    );

    hw_fw_timer #(.PRESCALE(P2), .SHORT_TICKS(S2), .LONG_TICKS(L2), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset), .timer_hw_reset(restart2),
`ifdef TMR_RUNTIME_CFG_EN
        .cfg_load(cfg_load2), .cfg_short(cfg_short2), .cfg_long(cfg_long2), .cfg_err(cfg_err2),
`endif
        .tick(tick2), .short_timeout(short2), .long_timeout(long2),
        .elapsed(elapsed2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_tick(int k, int p);
        return (k > 0 && (k % p) == 0) ? 1 : 0;
    endfunction

    function automatic int m_elapsed(int k, int p, int l);
        return ((k / p) < l) ? (k / p) : l;
    endfunction

    function automatic int m_after(int k, int p, int lim);
        return (k >= lim * p + 1) ? 1 : 0;
    endfunction

    task automatic check_all();
        check("tick",     int'(tick),          m_tick(k1, P));
        check("elapsed",  int'(elapsed),       m_elapsed(k1, P, ll));
        check("short",    int'(short_timeout), m_after(k1, P, ls));
        check("long",     int'(long_timeout),  m_after(k1, P, ll));
        check("tick2",    int'(tick2),         m_tick(k2, P2));
        check("elapsed2", int'(elapsed2),      m_elapsed(k2, P2, L2));
        check("short2",   int'(short2),        m_after(k2, P2, S2));
        check("long2",    int'(long2),         m_after(k2, P2, L2));
`ifdef TMR_RUNTIME_CFG_EN
        check("cfg_err",  int'(cfg_err),       err_exp);
        check("cfg_err2", int'(cfg_err2),      0);
`endif
    endtask

    task automatic model_reset();
        k1 = 0; k2 = 0;
        ls = S; ll = L; ss = S; sl = L;
        err_exp = 0;
    endtask

    // One clock: model advances with the inputs held across the edge, then outputs are compared.
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
`ifdef TMR_RUNTIME_CFG_EN
            begin
                bit ok;
                ok = cfg_load && cfg_short >= 1 && cfg_short < cfg_long;
                err_exp = (cfg_load && !ok) ? 1 : 0;
                if (timer_hw_reset) begin
                    ls = ok ? int'(cfg_short) : ss;
                    ll = ok ? int'(cfg_long)  : sl;
                end
                if (ok) begin
                    ss = int'(cfg_short);
                    sl = int'(cfg_long);
                end
            end
`endif
            if (timer_hw_reset) k1 = 0; else k1++;
            k2++;
        end
        #1;
        check_all();
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        #1 reset = 1'b0;
        #1;
        model_reset();
        check("rst_tick",  int'(tick),          0);
        check("rst_elap",  int'(elapsed),       0);
        check("rst_short", int'(short_timeout), 0);
        check("rst_long",  int'(long_timeout),  0);
        check("rst_tick2", int'(tick2),         0);
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        timer_hw_reset = 1'b0;
        restart2 = 1'b0;
`ifdef TMR_RUNTIME_CFG_EN
        cfg_load = 1'b0; cfg_short = '0; cfg_long = '0;
        cfg_load2 = 1'b0; cfg_short2 = '0; cfg_long2 = '0;
`endif
        model_reset();
        #2;
        check("por_elap",  int'(elapsed),       0);
        check("por_short", int'(short_timeout), 0);
        repeat (2) cycle();
        reset = 1'b1;

        // Release from reset: timeouts at 9 and 21; fast instance at 2 and 3.
        for (int c = 1; c <= 24; c++) begin
            cycle();
            if (c == 8)  check("t1_short_c8",  int'(short_timeout), 0);
            if (c == 9)  check("t1_short_c9",  int'(short_timeout), 1);
            if (c == 20) check("t1_long_c20",  int'(long_timeout),  0);
            if (c == 21) check("t1_long_c21",  int'(long_timeout),  1);
            if (c == 1)  check("t5_short2_c1", int'(short2), 0);
            if (c == 2)  check("t5_short2_c2", int'(short2), 1);
            if (c == 2)  check("t5_long2_c2",  int'(long2),  0);
            if (c == 3)  check("t5_long2_c3",  int'(long2),  1);
            if (c <= 3)  check("t5_tick2",     int'(tick2),  1);
        end
        check("t1_sat", int'(elapsed), 5);

        // Restart from S_EXP.
        timer_hw_reset = 1'b1;
        cycle();
        timer_hw_reset = 1'b0;
        check("t2_short_clr", int'(short_timeout), 0);
        check("t2_long_clr",  int'(long_timeout),  0);
        for (int c = 1; c <= 9; c++) begin
            cycle();
            if (c == 8) check("t2_short_c8", int'(short_timeout), 0);
            if (c == 9) check("t2_short_c9", int'(short_timeout), 1);
        end

        // Restart coincident with a tick.
        begin
            int guard = 0;
            while ((k1 % P) != P - 1 && guard < 2 * P) begin
                cycle();
                guard++;
            end
            check("t3_align_timeout", ((k1 % P) == P - 1) ? 1 : 0, 1);
        end
        timer_hw_reset = 1'b1;
        cycle();
        timer_hw_reset = 1'b0;
        check("t3_elap0", int'(elapsed), 0);
        check("t3_tick0", int'(tick),    0);
        for (int c = 1; c <= 4; c++) begin
            cycle();
            check("t3_tick_gap", int'(tick), (c == 4) ? 1 : 0);
        end

        // Async reset with pre_cnt=2, elapsed=3.
        timer_hw_reset = 1'b1;
        cycle();
        timer_hw_reset = 1'b0;
        repeat (14) cycle();
        check("t4_elap3", int'(elapsed), 3);
        async_reset();

`ifdef TMR_RUNTIME_CFG_EN
        cfg_load = 1'b1; cfg_short = 8'd3; cfg_long = 8'd7;
        cycle();
        cfg_load = 1'b0;
        timer_hw_reset = 1'b1;
        cycle();
        timer_hw_reset = 1'b0;
        for (int c = 1; c <= 3 * P + 1; c++) begin
            cycle();
            if (c == 3 * P)     check("t6_short_early", int'(short_timeout), 0);
            if (c == 3 * P + 1) check("t6_short_at",    int'(short_timeout), 1);
        end
        cfg_load = 1'b1; cfg_short = 8'd7; cfg_long = 8'd3;
        cycle();
        cfg_load = 1'b0;
        check("t6_err_pulse", int'(cfg_err), 1);
        cycle();
        check("t6_err_clear", int'(cfg_err), 0);
        timer_hw_reset = 1'b1;
        cycle();
        timer_hw_reset = 1'b0;
        for (int c = 1; c <= 3 * P + 1; c++) begin
            cycle();
            if (c == 3 * P + 1) check("t6_limits_kept", int'(short_timeout), 1);
        end
`endif

        // Randomized restarts, held restarts and occasional mid-count resets.
        for (int i = 0; i < 3000; i++) begin
            timer_hw_reset = ($urandom_range(0, 29) == 0) ||
                             (timer_hw_reset && $urandom_range(0, 1) == 0);
`ifdef TMR_RUNTIME_CFG_EN
            cfg_load  = ($urandom_range(0, 19) == 0);
            cfg_short = 8'($urandom_range(0, 7));
            cfg_long  = 8'($urandom_range(0, 8));
`endif
            if ($urandom_range(0, 399) == 0) begin
                timer_hw_reset = 1'b0;
`ifdef TMR_RUNTIME_CFG_EN
                cfg_load = 1'b0;
`endif
                async_reset();
            end else begin
                cycle();
            end
        end
        timer_hw_reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
